// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag layout, FP32 field widths,
// the canonical quiet NaN, and the retire-buffer occupancy states.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int SIG_W = 23;

  localparam logic [31:0] CANON_NAN = 32'h7fc00000;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;

  // True for any FP32 NaN (all-ones exponent, nonzero significand).
  function automatic logic is_nan(input logic [31:0] word);
    return (word[SIG_W +: EXP_W] == {EXP_W{1'b1}}) && (word[SIG_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fpu_retire_fifo.sv
// Result buffer for fpu_retire: DEPTH-entry FIFO with wrapping pointers and
// an occupancy counter; EMPTY/PARTIAL/FULL are derived from the counter.
module fpu_retire_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  occ_state_t       occ;
  logic             do_push;
  logic             do_pop;

  // Classify occupancy so full/empty come from registered state only.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0) begin
      occ = OCC_EMPTY;
    end else if (count == FULL_COUNT) begin
      occ = OCC_FULL;
    end
  end

  assign full     = (occ == OCC_FULL);
  assign empty    = (occ == OCC_EMPTY);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are unreachable once count clears.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fpu_retire.sv
// FPU result retire stage: buffers FPU results, sanitizes exception flags,
// accumulates sticky fflags and counts invalid-operation retires.
// Optional feature macro FPU_RETIRE_CANON_NAN_EN: replace every captured NaN
// with the canonical quiet NaN; without it results are stored bit-exact.
module fpu_retire
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  input  logic             csr_wr,
  input  logic [4:0]       csr_wdata,
  output logic [4:0]       csr_fflags,
  output logic [CNT_W-1:0] nv_count
);

  localparam logic [CNT_W-1:0] NV_MAX = '1;

  fflags_t     cap_flags;
  logic [31:0] cap_result;
  logic [36:0] pop_word;
  logic        full;
  logic        empty;
  logic        retire;

  // Inexact is implied by overflow or underflow, so fold them into NX on capture.
  always_comb begin
    cap_flags    = in_flags;
    cap_flags.nx = in_flags[FLAG_NX] | in_flags[FLAG_OF] | in_flags[FLAG_UF];
  end

  // Result word as it enters the buffer.
`ifdef FPU_RETIRE_CANON_NAN_EN
  always_comb begin
    cap_result = in_result;
    if (is_nan(in_result)) begin
      cap_result = CANON_NAN;
    end
  end
`else
  always_comb begin
    cap_result = in_result;
  end
`endif

  fpu_retire_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(37)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_data({cap_flags, cap_result}),
    .pop      (out_ready),
    .pop_data (pop_word),
    .full     (full),
    .empty    (empty)
  );

  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_result = pop_word[31:0];
  assign out_flags  = pop_word[36:32];
  assign retire     = out_valid && out_ready;

  // Sticky flags: a CSR write replaces the value but never drops a retiring word's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_fflags <= '0;
    end else if (csr_wr && retire) begin
      csr_fflags <= csr_wdata | out_flags;
    end else if (csr_wr) begin
      csr_fflags <= csr_wdata;
    end else if (retire) begin
      csr_fflags <= csr_fflags | out_flags;
    end
  end

  // Saturating count of retired words carrying NV; CSR writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nv_count <= '0;
    end else if (retire && out_flags[FLAG_NV] && (nv_count != NV_MAX)) begin
      nv_count <= nv_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_retire.sv
// Testbench for fpu_retire: directed scenarios plus randomized traffic,
// checked by a queue-based scoreboard and a small reference model.
module tb_fpu_retire;

  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;
  localparam int NV_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic [4:0]       in_flags;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic             csr_wr;
  logic [4:0]       csr_wdata;
  logic [4:0]       csr_fflags;
  logic [CNT_W-1:0] nv_count;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q [$];
  logic [4:0]  model_ff  = '0;
  int          model_nv  = 0;
  bit          rand_ready = 1'b0;
  bit          rand_csr   = 1'b0;

  fpu_retire #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .csr_wr    (csr_wr),
    .csr_wdata (csr_wdata),
    .csr_fflags(csr_fflags),
    .nv_count  (nv_count)
  );

  always #5 clk = ~clk;

  // What a captured result should look like when it leaves the buffer.
  function automatic logic [36:0] expectWord(input logic [31:0] r, input logic [4:0] f);
    logic [4:0]  ef;
    logic [31:0] er;
    ef = f;
    if (f[2] || f[1]) ef[0] = 1'b1;
    er = r;
`ifdef FPU_RETIRE_CANON_NAN_EN
    if (r[30:23] == 8'hff && r[22:0] != 23'd0) er = 32'h7fc00000;
`endif
    return {ef, er};
  endfunction

  task automatic checkOutput(input string name, input logic [36:0] act, input logic [36:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle control randomization, applied just after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    if (rand_csr) begin
      csr_wr    = ($urandom_range(0, 7) == 0);
      csr_wdata = 5'($urandom);
    end
  endtask

  // Offer one result and hold it until accepted or the budget runs out.
  task automatic applyStimulus(input logic [31:0] r, input logic [4:0] f, input int budget);
    bit accepted;
    int waited;
    accepted  = 1'b0;
    waited    = 0;
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    while (!accepted && waited < budget) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      if (accepted) exp_q.push_back(expectWord(r, f));
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      if (rand_csr) begin
        csr_wr    = ($urandom_range(0, 7) == 0);
        csr_wdata = 5'($urandom);
      end
      waited++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout in_ready stayed 0 for %0d cycles, required 1", budget);
    end
  endtask

  // Assert reset between edges and confirm it takes effect without a clock.
  task automatic resetMidCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_csr_fflags", csr_fflags, 0);
    checkOutput("rst_nv_count", nv_count, 0);
    exp_q.delete();
    model_ff = '0;
    model_nv = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the scoreboard and advances the model on retire.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst) begin
      checkOutput("in_ready", in_ready, (exp_q.size() < DEPTH));
      checkOutput("out_valid", out_valid, (exp_q.size() != 0));
      checkOutput("csr_fflags", csr_fflags, model_ff);
      checkOutput("nv_count", nv_count, 37'(model_nv));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        checkOutput("out_word", {out_flags, out_result}, e);
        if (out_ready) begin
          void'(exp_q.pop_front());
          model_ff = (csr_wr ? csr_wdata : model_ff) | e[36:32];
          if (e[36] && model_nv < NV_SAT) model_nv++;
        end else if (csr_wr) begin
          model_ff = csr_wdata;
        end
      end else if (csr_wr) begin
        model_ff = csr_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    int          nv_before;
    int          w;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    out_ready = 1'b0;
    csr_wr    = 1'b0;
    csr_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_csr_fflags", csr_fflags, 0);
    checkOutput("reset_nv_count", nv_count, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single result, one-cycle latency");
    out_ready = 1'b1;
    applyStimulus(32'h40c00001, 5'b00001, 5);
    tick();
    @(negedge clk);
    checkOutput("first_csr_fflags", csr_fflags, 5'b00001);
    tick();

    $display("[TB] fill buffer, then drain in order");
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus($urandom, 5'($urandom), 5);
    held      = $urandom;
    in_valid  = 1'b1;
    in_result = held;
    in_flags  = 5'b01000;
    tick();
    tick();
    out_ready = 1'b1;
    applyStimulus(held, 5'b01000, 10);
    repeat (DEPTH + 2) tick();

    $display("[TB] overflow implies inexact");
    applyStimulus(32'h7f7fffff, 5'b00100, 5);
    repeat (2) tick();

    $display("[TB] CSR write coincident with NV retire");
    out_ready = 1'b0;
    applyStimulus(32'h7fc00000, 5'b10000, 5);
    nv_before = model_nv;
    out_ready = 1'b1;
    csr_wr    = 1'b1;
    csr_wdata = 5'b00010;
    tick();
    csr_wr = 1'b0;
    @(negedge clk);
    checkOutput("csr_wr_retire", csr_fflags, 5'b10010);
    checkOutput("nv_incr", nv_count, 37'(nv_before + 1));
    tick();

    $display("[TB] NV counter saturation");
    for (int i = 0; i < (1 << CNT_W) + 3; i++) applyStimulus($urandom, {1'b1, 4'($urandom)}, 5);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("nv_saturated", nv_count, 37'(NV_SAT));
    tick();

    $display("[TB] NaN payload handling");
    applyStimulus(32'hffc12345, 5'b10000, 5);
    repeat (2) tick();

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    rand_csr   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = {r[31], 8'hff, r[22:1], 1'b1};
      applyStimulus(r, 5'($urandom), 20);
      if ($urandom_range(0, 2) == 0) tick();
    end
    rand_ready = 1'b0;
    rand_csr   = 1'b0;
    csr_wr     = 1'b0;
    out_ready  = 1'b1;
    repeat (DEPTH + 2) tick();

    $display("[TB] asynchronous reset with one buffered entry");
    out_ready = 1'b0;
    applyStimulus(32'h3f800000, 5'b10101, 5);
    tick();
    resetMidCycle();
    out_ready = 1'b1;
    applyStimulus(32'h40490fdb, 5'b00001, 5);
    tick();
    @(negedge clk);
    checkOutput("post_reset_csr", csr_fflags, 5'b00001);
    tick();

    w = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain entries_left=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
